router_pkt_reader: RTL and testbench
====================================

Name: router_pkt_reader

Overview:
- Destination-side reader that drains one router output FIFO.
- Issues read enables to the FIFO and tracks packet framing: header, payload and trailing parity byte.
- Presents header and payload bytes to the client on a valid/ready interface with sop/eop marks.
- Checks parity and enforces the client read timeout that triggers the FIFO soft reset.

Parameters:
- TIMEOUT, 30, cycles out_valid may stay high without out_ready before soft reset.
- LEN_W, 6, width of the header payload-length field (header bits [7:2]).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after a rd_en with !fifo_empty
- fifo_rd_en  out  1  FIFO read enable
- soft_rst  out  1  one-cycle pulse to FIFO on timeout
- out_data  out  8  byte to client
- out_valid  out  1  out_data valid
- out_ready  in  1  client accepts byte
- out_sop  out  1  out_data is the header byte
- out_eop  out  1  out_data is the last byte of the packet (last payload byte, or the header when len=0)
- parity_err  out  1  one-cycle pulse: received parity differs from computed parity
- pkt_done  out  1  one-cycle pulse when the parity byte is consumed
- busy  out  1  high from header arrival until parity consumed

Behaviour:
- Reset (rstn=0 at posedge clk) drives all outputs to 0, empties the buffer, sets state IDLE and clears all counters and the in-flight flag.
- Packet format:
  - header = {len[5:0], addr[1:0]}; len = 0..63.
  - Then len payload bytes.
  - Then one parity byte = XOR of header and all payload bytes.
- Read issue:
  - fifo_rd_en = !fifo_empty && !soft_rst && (buf_cnt - pop + inflight) < 2.
  - pop = out_valid && out_ready.
  - inflight = fifo_rd_en registered for one cycle.
- Arrival: the byte arrives in the cycle where inflight=1; it is classified by state.
- Output buffer:
  - 2-entry FIFO of {data, sop, eop}; head drives out_data/out_sop/out_eop; out_valid = buf_cnt != 0.
  - Push and pop in the same cycle are allowed.
  - Gives 1 byte/cycle sustained throughput with out_ready high.
- State machine (state changes on arrival):
  - IDLE: the byte is the header.
    - Push it with sop=1 and eop=(len==0).
    - Set rem = len and par = byte.
    - Go to PAYLOAD if len!=0, else PARITY.
  - PAYLOAD:
    - Push the byte with eop=(rem==1), set par ^= byte, decrement rem.
    - When rem==1, go to PARITY.
  - PARITY: the byte is not pushed.
    - parity_err = (byte != par) next cycle.
    - pkt_done=1 next cycle.
    - Go to IDLE.
- busy = state != IDLE.
- Timeout:
  - tcnt increments each cycle that out_valid && !out_ready, and clears on a pop or when out_valid=0.
  - When tcnt reaches TIMEOUT-1 with the condition still true, soft_rst pulses for 1 cycle the next cycle.
  - In that same cycle: buffer flushed, in-flight byte discarded, state IDLE, rem/par/tcnt cleared. No parity_err or pkt_done is generated.
- fifo_rd_en is held 0 during the soft_rst cycle.
- Reset mid-packet: identical to power-on reset; no partial-packet flags.
- Width rules: rem is LEN_W bits; tcnt is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package router_pkg:
  - Header field constants LEN_LSB=2 and ADDR_W=2.
  - State typedef {IDLE, PAYLOAD, PARITY}.
  - Byte width constant 8.
- One sub-module: router_out_skid, the 2-entry output buffer with push/pop/count.

Test Plan:
- Packet header 0x0D (len=3, addr=1), payload 0x11 0x22 0x33, parity 0x0D^0x11^0x22^0x33=0x0D, out_ready=1 -> out_data 0x0D(sop) 0x11 0x22 0x33(eop) on consecutive cycles; pkt_done pulses; parity_err=0.
- Same packet with out_ready toggling 1/0 every cycle -> identical byte order and sop/eop; fifo_rd_en never raised with buf_cnt+inflight=2; no byte lost or duplicated.
- Header 0x02 (len=0, addr=2), parity 0x02 -> single output byte 0x02 with sop=eop=1; pkt_done pulses.
- Len=2 packet with a corrupted parity byte 0xFF -> all bytes delivered, then parity_err=1 for exactly 1 cycle alongside pkt_done.
- Header delivered and out_ready held 0 -> soft_rst pulses exactly once, 30 cycles after out_valid rises; then out_valid=0, busy=0, state IDLE; next packet is parsed correctly.
- rstn=0 for 1 cycle after 2 payload bytes of a len=5 packet -> all outputs 0; a fresh header then produces sop with no stale eop or parity_err.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router packet reader.
//   BYTE_W  : width of one FIFO / client byte
//   LEN_LSB : bit position of the payload-length field inside the header
//   ADDR_W  : width of the address field in the header low bits
//   state_t : framing state of the packet reader
//   beat_t  : one entry of the output buffer {data, sop, eop}
package router_pkg;

  localparam int BYTE_W  = 8;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

endpackage

// File: rtl/router_pkt_reader_if.sv
// Client-side byte stream of the packet reader.
//   out_data  : byte to client
//   out_valid : out_data valid
//   out_ready : client accepts the byte
//   out_sop   : byte is the packet header
//   out_eop   : byte is the last delivered byte of the packet
// master = the reader (drives the stream), slave = the client.
interface router_pkt_reader_if;
  import router_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );

endinterface

// File: rtl/router_out_skid.sv
// Two-entry output buffer between the packet parser and the client.
// Push and pop may happen in the same cycle, which keeps one byte per cycle
// flowing while the client is ready. The head entry reads as zero when empty.
//   clk, rstn : clock, synchronous active-low reset
//   flush     : drop all entries (takes priority over push/pop)
//   push      : write push_beat at the tail
//   push_beat : entry to write
//   pop       : remove the head entry
//   head      : current head entry (zero when empty)
//   count     : number of valid entries, 0..2
module router_out_skid
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      mem [2];
  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  logic       do_pop;

  // A pop on an empty buffer is ignored so the count cannot wrap.
  assign do_pop = pop && (count_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= push_beat;
        wr_ptr_reg      <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  assign head  = (count_reg != 2'd0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side reader for one router output FIFO.
// Reads bytes from the FIFO, frames them as header / payload / parity,
// forwards header and payload to the client with sop/eop marks, checks the
// trailing parity byte and fires a FIFO soft reset if the client stalls.
//   clk, rstn  : clock, synchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data, valid the cycle after an accepted rd_en
//   fifo_rd_en : FIFO read enable
//   soft_rst   : one-cycle pulse to the FIFO on client timeout
//   out_if     : client byte stream (master side)
//   parity_err : one-cycle pulse, received parity differs from computed
//   pkt_done   : one-cycle pulse when the parity byte is consumed
//   busy       : high from header arrival until parity consumed
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int LEN_W   = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fifo_empty,
  input  logic [BYTE_W-1:0]   fifo_dout,
  output logic                fifo_rd_en,
  output logic                soft_rst,
  router_pkt_reader_if.master out_if,
  output logic                parity_err,
  output logic                pkt_done,
  output logic                busy
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    rem_reg, rem_next;
  logic [BYTE_W-1:0]   par_reg, par_next;
  logic [TCNT_W-1:0]   tcnt_reg;
  logic                inflight_reg;
  logic                soft_rst_reg;
  logic                parity_err_reg, parity_err_next;
  logic                pkt_done_reg, pkt_done_next;

  logic [1:0]          buf_cnt;
  beat_t               head;
  beat_t               push_beat;
  logic                push;
  logic                pop;
  logic                arrive;
  logic                stall;
  logic                fire;
  logic [2:0]          occ;
  logic [LEN_W-1:0]    hdr_len;

  assign pop = out_if.out_valid && out_if.out_ready;

  // Occupancy the buffer will have once this cycle's pop and the byte
  // already in flight are accounted for; never request a third byte.
  assign occ        = {1'b0, buf_cnt} - {2'b0, pop} + {2'b0, inflight_reg};
  assign fifo_rd_en = !fifo_empty && !soft_rst_reg && (occ < 3'd2);

  // A byte landing during the soft reset cycle belongs to the flushed FIFO.
  assign arrive  = inflight_reg && !soft_rst_reg;
  assign hdr_len = fifo_dout[LEN_LSB +: LEN_W];

  assign stall = out_if.out_valid && !out_if.out_ready;
  assign fire  = stall && !soft_rst_reg && (tcnt_reg == TCNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next      = state_reg;
    rem_next        = rem_reg;
    par_next        = par_reg;
    push            = 1'b0;
    push_beat       = '0;
    parity_err_next = 1'b0;
    pkt_done_next   = 1'b0;

    if (arrive) begin
      unique case (state_reg)
        IDLE: begin
          push           = 1'b1;
          push_beat.data = fifo_dout;
          push_beat.sop  = 1'b1;
          push_beat.eop  = (hdr_len == '0);
          rem_next       = hdr_len;
          par_next       = fifo_dout;
          state_next     = (hdr_len != '0) ? PAYLOAD : PARITY;
        end
        PAYLOAD: begin
          push           = 1'b1;
          push_beat.data = fifo_dout;
          push_beat.eop  = (rem_reg == LEN_W'(1));
          par_next       = par_reg ^ fifo_dout;
          rem_next       = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_err_next = (fifo_dout != par_reg);
          pkt_done_next   = 1'b1;
          state_next      = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    if (soft_rst_reg) begin
      state_next = IDLE;
      rem_next   = '0;
      par_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      rem_reg        <= '0;
      par_reg        <= '0;
      tcnt_reg       <= '0;
      inflight_reg   <= 1'b0;
      soft_rst_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      pkt_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      par_reg        <= par_next;
      inflight_reg   <= fifo_rd_en;
      soft_rst_reg   <= fire;
      parity_err_reg <= parity_err_next;
      pkt_done_reg   <= pkt_done_next;
      // Stall counter saturates; it only needs to pass TIMEOUT-1 once.
      if (soft_rst_reg || !stall) begin
        tcnt_reg <= '0;
      end else if (tcnt_reg != {TCNT_W{1'b1}}) begin
        tcnt_reg <= tcnt_reg + TCNT_W'(1);
      end
    end
  end

  router_out_skid u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (soft_rst_reg),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (buf_cnt)
  );

  assign out_if.out_valid = (buf_cnt != 2'd0);
  assign out_if.out_data  = head.data;
  assign out_if.out_sop   = head.sop;
  assign out_if.out_eop   = head.eop;

  assign soft_rst   = soft_rst_reg;
  assign parity_err = parity_err_reg;
  assign pkt_done   = pkt_done_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_router_pkt_reader.sv
module tb_router_pkt_reader;

  localparam int TIMEOUT = 30;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       par;
    logic       bad;
  } item_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       soft_rst;
  logic       parity_err;
  logic       pkt_done;
  logic       busy;

  router_pkt_reader_if bus ();

  router_pkt_reader #(.TIMEOUT(TIMEOUT), .LEN_W(6)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .soft_rst   (soft_rst),
    .out_if     (bus.master),
    .parity_err (parity_err),
    .pkt_done   (pkt_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bench-side FIFO and behavioural model of the expected client stream.
  item_t fifo_q[$];
  item_t exp_q[$];
  item_t infl_item;
  logic  infl_valid = 1'b0;
  logic  m_busy = 1'b0;
  logic  exp_srst = 1'b0;
  logic  exp_done = 1'b0;
  logic  exp_perr = 1'b0;
  int    run = 0;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  logic  chk_en = 1'b0;
  logic  rst_req = 1'b1;
  int    ready_mode = 0;  // 0 always ready, 1 toggle, 2 never, 3 random
  int    ready_thr = 12;
  int    pkt_seen = 0;

  // Per-test observation logs of what the DUT delivered.
  logic [7:0] log_data[$];
  logic       log_sop[$];
  logic       log_eop[$];
  int         log_cyc[$];
  int         done_cnt = 0;
  int         perr_cnt = 0;
  int         srst_cnt = 0;
  int         srst_cyc = -1;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d: wait bound expired", name, cyc);
  endtask

  task automatic clear_logs();
    log_data.delete(); log_sop.delete(); log_eop.delete(); log_cyc.delete();
    done_cnt = 0; perr_cnt = 0; srst_cnt = 0; srst_cyc = -1; rise_cyc = -1;
  endtask

  task automatic load_pkt(input int len, input logic [1:0] addr, input logic force_par,
                          input logic [7:0] par_val, input logic [7:0] p0,
                          input logic [7:0] p1, input logic [7:0] p2);
    item_t      it;
    logic [7:0] par, b;
    it.data = {len[5:0], addr}; it.sop = 1'b1; it.eop = (len == 0);
    it.par = 1'b0; it.bad = 1'b0;
    par = it.data;
    fifo_q.push_back(it);
    for (int i = 0; i < len; i++) begin
      b = (i == 0) ? p0 : (i == 1) ? p1 : (i == 2) ? p2 : 8'($urandom);
      par = par ^ b;
      it.data = b; it.sop = 1'b0; it.eop = (i == len - 1); it.par = 1'b0; it.bad = 1'b0;
      fifo_q.push_back(it);
    end
    b = force_par ? par_val : par;
    it.data = b; it.sop = 1'b0; it.eop = 1'b0; it.par = 1'b1; it.bad = (b != par);
    fifo_q.push_back(it);
  endtask

  task automatic model_reset();
    fifo_q.delete(); exp_q.delete();
    infl_valid = 1'b0; m_busy = 1'b0; run = 0;
    exp_srst = 1'b0; exp_done = 1'b0; exp_perr = 1'b0;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge,
  // then advance the model to what the next cycle must show.
  task automatic step();
    logic pop, rd, stall, n_srst, n_done, n_perr;
    int   occ;
    @(posedge clk); #1;
    rstn = !rst_req;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = cyc[0];
      2: bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 15) < ready_thr);
    endcase
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = infl_valid ? infl_item.data : 8'($urandom);
    @(negedge clk);
    cyc++;
    occ = exp_q.size();
    if (chk_en) begin
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, occ != 0});
      if (occ != 0) begin
        chk("out_data", {24'b0, bus.out_data}, {24'b0, exp_q[0].data});
        chk("out_sop", {31'b0, bus.out_sop}, {31'b0, exp_q[0].sop});
        chk("out_eop", {31'b0, bus.out_eop}, {31'b0, exp_q[0].eop});
      end
      chk("soft_rst", {31'b0, soft_rst}, {31'b0, exp_srst});
      chk("pkt_done", {31'b0, pkt_done}, {31'b0, exp_done});
      chk("parity_err", {31'b0, parity_err}, {31'b0, exp_perr});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
    end
    pop   = (occ != 0) && bus.out_ready;
    stall = (occ != 0) && !bus.out_ready;
    rd = !fifo_empty && !exp_srst && ((occ - (pop ? 1 : 0) + (infl_valid ? 1 : 0)) < 2);
    if (chk_en) chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, rd});

    if (bus.out_valid && bus.out_ready) begin
      log_data.push_back(bus.out_data); log_sop.push_back(bus.out_sop);
      log_eop.push_back(bus.out_eop); log_cyc.push_back(cyc);
    end
    if (bus.out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = bus.out_valid;
    if (soft_rst) begin srst_cnt++; srst_cyc = cyc; end
    if (parity_err) perr_cnt++;
    if (pkt_done) begin
      done_cnt++; pkt_seen++;
      $display("pkt %0d done at cycle %0d parity_err=%0d", pkt_seen, cyc, parity_err);
    end

    n_srst = 1'b0; n_done = 1'b0; n_perr = 1'b0;
    if (!rstn) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (infl_valid && !exp_srst) begin
        if (infl_item.par) begin
          n_done = 1'b1; n_perr = infl_item.bad; m_busy = 1'b0;
        end else begin
          exp_q.push_back(infl_item);
          if (infl_item.sop) m_busy = 1'b1;
        end
      end
      if (exp_srst) begin
        exp_q.delete(); fifo_q.delete(); m_busy = 1'b0; run = 0;
      end else if (stall) begin
        run++;
        if (run == TIMEOUT) begin n_srst = 1'b1; run = 0; end
      end else begin
        run = 0;
      end
      infl_valid = rd;
      if (rd) infl_item = fifo_q.pop_front();
      exp_srst = n_srst; exp_done = n_done; exp_perr = n_perr;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (fifo_q.size() != 0 || infl_valid || exp_q.size() != 0 || m_busy || exp_done) begin
      step();
      n++;
      if (n > budget) begin bound_fail(name); break; end
    end
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_data"}, {24'b0, bus.out_data}, 32'd0);
    chk({tag, "_sop"}, {31'b0, bus.out_sop}, 32'd0);
    chk({tag, "_eop"}, {31'b0, bus.out_eop}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_srst"}, {31'b0, soft_rst}, 32'd0);
    chk({tag, "_done"}, {31'b0, pkt_done}, 32'd0);
    chk({tag, "_perr"}, {31'b0, parity_err}, 32'd0);
    chk({tag, "_rd_en"}, {31'b0, fifo_rd_en}, 32'd0);
  endtask

  task automatic check_pkt_0d(input string tag, input logic consecutive);
    logic [7:0] want [4];
    want[0] = 8'h0D; want[1] = 8'h11; want[2] = 8'h22; want[3] = 8'h33;
    chk({tag, "_count"}, log_data.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      chk({tag, "_byte"}, {24'b0, log_data[i]}, {24'b0, want[i]});
      chk({tag, "_sop"}, {31'b0, log_sop[i]}, {31'b0, i == 0});
      chk({tag, "_eop"}, {31'b0, log_eop[i]}, {31'b0, i == 3});
      if (consecutive) chk({tag, "_cycle"}, log_cyc[i] - log_cyc[0], i);
    end
    chk({tag, "_done_cnt"}, done_cnt, 32'd1);
    chk({tag, "_perr_cnt"}, perr_cnt, 32'd0);
  endtask

  initial begin
    int n;
    bus.out_ready = 1'b1;
    // Power-on reset.
    rst_req = 1'b1;
    step();
    chk_en = 1'b1;
    step(); step();
    rst_req = 1'b0;
    step();
    check_idle_outputs("reset");

    // Basic packet, client always ready.
    clear_logs(); ready_mode = 0;
    load_pkt(3, 2'd1, 1'b0, 8'h00, 8'h11, 8'h22, 8'h33);
    drain("drain_basic", 200);
    check_pkt_0d("basic", 1'b1);

    // Same packet with the client toggling ready.
    clear_logs(); ready_mode = 1;
    load_pkt(3, 2'd1, 1'b0, 8'h00, 8'h11, 8'h22, 8'h33);
    drain("drain_toggle", 200);
    check_pkt_0d("toggle", 1'b0);

    // Zero-length packet: header is both sop and eop.
    clear_logs(); ready_mode = 0;
    load_pkt(0, 2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    drain("drain_len0", 200);
    chk("len0_count", log_data.size(), 32'd1);
    if (log_data.size() > 0) begin
      chk("len0_byte", {24'b0, log_data[0]}, 32'h02);
      chk("len0_sop", {31'b0, log_sop[0]}, 32'd1);
      chk("len0_eop", {31'b0, log_eop[0]}, 32'd1);
    end
    chk("len0_done", done_cnt, 32'd1);

    // Corrupted parity on a len=2 packet (true parity 0x08^0xA5^0x3C = 0x91).
    clear_logs();
    load_pkt(2, 2'd0, 1'b1, 8'hFF, 8'hA5, 8'h3C, 8'h00);
    drain("drain_badpar", 200);
    chk("badpar_count", log_data.size(), 32'd3);
    chk("badpar_perr_cnt", perr_cnt, 32'd1);
    chk("badpar_done_cnt", done_cnt, 32'd1);

    // Client never ready: soft reset 30 cycles after out_valid rises.
    clear_logs(); ready_mode = 2;
    fifo_q.push_back('{data: 8'h0D, sop: 1'b1, eop: 1'b0, par: 1'b0, bad: 1'b0});
    n = 0;
    while (srst_cnt == 0) begin
      step(); n++;
      if (n > 200) begin bound_fail("timeout_wait"); break; end
    end
    for (int i = 0; i < 40; i++) step();
    chk("timeout_srst_cnt", srst_cnt, 32'd1);
    chk("timeout_delay", srst_cyc - rise_cyc, TIMEOUT);
    chk("timeout_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    chk("timeout_done", done_cnt, 32'd0);
    clear_logs(); ready_mode = 0;
    load_pkt(3, 2'd1, 1'b0, 8'h00, 8'h11, 8'h22, 8'h33);
    drain("drain_after_timeout", 200);
    check_pkt_0d("after_timeout", 1'b1);

    // Reset in the middle of a len=5 packet.
    clear_logs(); ready_mode = 0;
    load_pkt(5, 2'd1, 1'b0, 8'h00, 8'h41, 8'h42, 8'h43);
    n = 0;
    while (log_data.size() < 3) begin
      step(); n++;
      if (n > 100) begin bound_fail("midrst_wait"); break; end
    end
    rst_req = 1'b1; step();
    rst_req = 1'b0; step();
    check_idle_outputs("midrst");
    clear_logs();
    load_pkt(1, 2'd2, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h00);
    drain("drain_midrst", 200);
    chk("midrst_count", log_data.size(), 32'd2);
    if (log_data.size() == 2) begin
      chk("midrst_hdr", {24'b0, log_data[0]}, 32'h06);
      chk("midrst_sop", {31'b0, log_sop[0]}, 32'd1);
      chk("midrst_hdr_eop", {31'b0, log_eop[0]}, 32'd0);
      chk("midrst_last_eop", {31'b0, log_eop[1]}, 32'd1);
    end
    chk("midrst_perr", perr_cnt, 32'd0);
    chk("midrst_done", done_cnt, 32'd1);

    // Randomized traffic: mostly-ready client, then a sluggish one that times out.
    for (int phase = 0; phase < 2; phase++) begin
      int left;
      int maxlen;
      left       = (phase == 0) ? 120 : 25;
      maxlen     = (phase == 0) ? 63 : 12;
      ready_mode = 3;
      ready_thr  = (phase == 0) ? 12 : 1;
      n = 0;
      while (left > 0) begin
        if (fifo_q.size() < 3 && $urandom_range(0, 1) == 1) begin
          load_pkt($urandom_range(0, maxlen), 2'($urandom), ($urandom_range(0, 5) == 0),
                   8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
          left--;
        end
        step(); n++;
        if (n > 40000) begin bound_fail("random_budget"); break; end
      end
      ready_mode = 0;
      drain("drain_random", 1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
